// File: rtl/l2_xbar_wrr_arb.sv
// rtl/l2_xbar_wrr_arb.sv - weighted round-robin arbiter for one L2 bank port
//
// Purpose:
//   Shares a single L2 bank port between requesters (0 = PE, 1 = DMA).
//   One address-phase grant is offered at a time. Each requester spends one
//   credit per grant, and credits are refilled from weight_i once a requester
//   that is waiting has run dry. In-flight transactions per requester are
//   capped using completion feedback from the bank side.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_valid_i/len_i    per-requester address phase pending + burst length
//   req_ready_o          per-requester accept (pass-through of gnt_ready_i)
//   weight_i             per-requester grants per round, 0 behaves as 1
//   gnt_valid_o/idx_o/len_o, gnt_ready_i   grant offered to the bank port
//   done_i, done_idx_i   one transaction of done_idx_i completed
//   busy_o               any transaction in flight
//   err_o                sticky: completion seen with nothing in flight
//
// Optional feature macro: L2_XBAR_ARB_PERF_CNT_EN adds perf_gnt_o and
//   perf_stall_o (32-bit wrapping counters per requester).
module l2_xbar_wrr_arb #(
   parameter int NumReq         = 2,
   parameter int WeightWidth    = 4,
   parameter int MaxOutstanding = 8,
   parameter int LenWidth       = 8,
   localparam int IdxWidth      = (NumReq > 1) ? $clog2(NumReq) : 1,
   localparam int OutWidth      = $clog2(MaxOutstanding + 1)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NumReq-1:0]             req_valid_i,
   input  logic [NumReq*LenWidth-1:0]    req_len_i,
   output logic [NumReq-1:0]             req_ready_o,
   input  logic [NumReq*WeightWidth-1:0] weight_i,
   output logic                          gnt_valid_o,
   output logic [IdxWidth-1:0]           gnt_idx_o,
   output logic [LenWidth-1:0]           gnt_len_o,
   input  logic                          gnt_ready_i,
   input  logic                          done_i,
   input  logic [IdxWidth-1:0]           done_idx_i,
   output logic                          busy_o,
   output logic                          err_o
`ifdef L2_XBAR_ARB_PERF_CNT_EN
   ,
   output logic [NumReq*32-1:0]          perf_gnt_o,
   output logic [NumReq*32-1:0]          perf_stall_o
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      OFFER  = 2'd2
   } state_e;

   localparam logic [OutWidth-1:0] MaxOut = OutWidth'(MaxOutstanding);

   state_e                 state_q, state_d;
   logic [WeightWidth-1:0] credit_q [NumReq];
   logic [OutWidth-1:0]    outst_q  [NumReq];
   logic [IdxWidth-1:0]    rr_q, idx_q, pick, cand;
   logic [LenWidth-1:0]    len_q;
   logic                   err_q;
   logic                   found;
   logic                   handshake;
   logic [NumReq-1:0]      eligible, starved, inc, dec, inflight;

   // Eligibility: a requester at its in-flight cap is neither eligible nor
   // starved, so it can never trigger a refill on its own.
   always_comb begin
      eligible = '0;
      starved  = '0;
      inflight = '0;
      for (int i = 0; i < NumReq; i++) begin
         eligible[i] = req_valid_i[i] && (credit_q[i] != '0) && (outst_q[i] < MaxOut);
         starved[i]  = req_valid_i[i] && (credit_q[i] == '0) && (outst_q[i] < MaxOut);
         inflight[i] = (outst_q[i] != '0);
      end
   end

   // First eligible requester at or after the round-robin pointer.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 0; k < NumReq; k++) begin
         cand = IdxWidth'((int'(rr_q) + k) % NumReq);
         if (!found && eligible[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign handshake = (state_q == OFFER) && gnt_ready_i;

   always_comb begin
      inc = '0;
      dec = '0;
      if (handshake) inc[idx_q] = 1'b1;
      if (done_i)    dec[done_idx_i] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (found)         state_d = OFFER;
            else if (|starved) state_d = REFILL;
         end
         REFILL:               state_d = IDLE;
         OFFER: begin
            if (gnt_ready_i)   state_d = IDLE;
         end
         default:              state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q  <= '0;
         idx_q <= '0;
         len_q <= '0;
         err_q <= 1'b0;
         for (int i = 0; i < NumReq; i++) begin
            credit_q[i] <= '0;
            outst_q[i]  <= '0;
         end
      end else begin
         // Grant target is latched so idx/len stay stable for the whole offer.
         if (state_q == IDLE && found) begin
            idx_q <= pick;
            len_q <= req_len_i[int'(pick)*LenWidth +: LenWidth];
         end
         if (state_q == REFILL) begin
            for (int i = 0; i < NumReq; i++) begin
               if (weight_i[i*WeightWidth +: WeightWidth] == '0)
                  credit_q[i] <= WeightWidth'(1);
               else
                  credit_q[i] <= weight_i[i*WeightWidth +: WeightWidth];
            end
         end
         if (handshake) begin
            credit_q[idx_q] <= credit_q[idx_q] - WeightWidth'(1);
            rr_q <= (int'(idx_q) == NumReq - 1) ? '0 : idx_q + IdxWidth'(1);
         end
         // Issue and completion on the same requester in one cycle cancel out.
         for (int i = 0; i < NumReq; i++) begin
            if (inc[i] && !dec[i])
               outst_q[i] <= outst_q[i] + OutWidth'(1);
            else if (dec[i] && !inc[i] && (outst_q[i] != '0))
               outst_q[i] <= outst_q[i] - OutWidth'(1);
            if (dec[i] && (outst_q[i] == '0))
               err_q <= 1'b1;
         end
      end
   end

   always_comb begin
      req_ready_o = '0;
      if (handshake) req_ready_o[idx_q] = 1'b1;
   end

   assign gnt_valid_o = (state_q == OFFER);
   assign gnt_idx_o   = idx_q;
   assign gnt_len_o   = len_q;
   assign busy_o      = |inflight;
   assign err_o       = err_q;

`ifdef L2_XBAR_ARB_PERF_CNT_EN
   logic [NumReq-1:0][31:0] perf_gnt_q, perf_stall_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_gnt_q   <= '0;
         perf_stall_q <= '0;
      end else begin
         for (int i = 0; i < NumReq; i++) begin
            if (req_ready_o[i])
               perf_gnt_q[i] <= perf_gnt_q[i] + 32'd1;
            if (req_valid_i[i] && !req_ready_o[i])
               perf_stall_q[i] <= perf_stall_q[i] + 32'd1;
         end
      end
   end

   assign perf_gnt_o   = perf_gnt_q;
   assign perf_stall_o = perf_stall_q;
`endif

endmodule
